game_sequencer: RTL and testbench

- Central scheduler for the snake game datapath: decides when the snake advances, which direction it moves, and when the board is cleared.
- Paces steps from VGA frame pulses, with a step period that shortens as the snake eats.
- Owns the game state machine: clear, ready, run, pause, fail, win.
- Sits between the input pins and the board/snake datapath; the datapath only acts on o_clear and o_step.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/dir_latch.sv | 51 +++++
 rtl/game_sequencer.sv | 167 ++++++++++++++++
 tb/tb_game_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game sequencer: directions, game states and counter widths.
package snake_pkg;

    localparam int unsigned FRAME_CNT_W = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_STEP  = 3'd4,
        ST_FAIL  = 3'd5,
        ST_WIN   = 3'd6
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   opposite = DIR_DOWN;
            DIR_DOWN: opposite = DIR_UP;
            DIR_LEFT: opposite = DIR_RIGHT;
            default:  opposite = DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/dir_latch.sv
// Button priority encoder with reversal rejection, holding the pending and committed
// snake directions; the sequencer strobes commit when a step is issued.
module dir_latch
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       sample,
    input  logic       commit,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [1:0] dir,
    output logic       accept_c
);

    dir_t req;
    dir_t pend;
    dir_t pend_next;
    dir_t dir_q;
    logic req_valid;

    always_comb begin
        req_valid = 1'b1;
        req       = DIR_RIGHT;
        if (up)         req = DIR_UP;
        else if (down)  req = DIR_DOWN;
        else if (left)  req = DIR_LEFT;
        else if (right) req = DIR_RIGHT;
        else            req_valid = 1'b0;
    end

    // A request that would reverse the snake onto itself is dropped.
    assign accept_c  = sample && req_valid && (req != opposite(dir_q));
    assign pend_next = accept_c ? req : pend;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            pend  <= DIR_RIGHT;
            dir_q <= DIR_RIGHT;
        end else begin
            pend <= pend_next;
            if (commit) dir_q <= pend_next;
        end
    end

    assign dir = dir_q;

endmodule

// File: rtl/game_sequencer.sv
// Snake game scheduler: paces steps from VGA frames, speeds up with eating,
// and runs the clear/ready/run/pause/step/fail/win state machine.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned FRAME_DIV_INIT = 8,
    parameter int unsigned FRAME_DIV_MIN  = 2,
    parameter int unsigned SPEEDUP_EVERY  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_pause,
    input  logic       i_restart,
    input  logic       i_step_done,
    input  logic       i_eat,
    input  logic       i_collision,
    input  logic       i_board_full,
    output logic       o_clear,
    output logic       o_step,
    output logic [1:0] o_dir,
    output logic [2:0] o_state,
    output logic       o_failure,
    output logic       o_success,
    output logic       o_eat,
    output logic       o_tick
);

    localparam logic [FRAME_CNT_W-1:0] DIV_INIT  = FRAME_CNT_W'(FRAME_DIV_INIT);
    localparam logic [FRAME_CNT_W-1:0] DIV_MIN   = FRAME_CNT_W'(FRAME_DIV_MIN);
    localparam logic [FRAME_CNT_W-1:0] EAT_LIMIT = FRAME_CNT_W'(SPEEDUP_EVERY);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);

    state_t                 state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [FRAME_CNT_W-1:0] frame_div;
    logic [FRAME_CNT_W-1:0] eat_cnt;
    logic                   restart_q;
    logic                   clear_issued;

    logic restart_rise_c;
    logic step_due_c;
    logic commit_c;
    logic sample_c;
    logic init_c;
    logic accept_c;

    assign restart_rise_c = i_restart && !restart_q;
    assign step_due_c     = (frame_cnt + CNT_ONE) == frame_div;
    assign commit_c       = !restart_rise_c && (state == ST_RUN) && i_frame_start
                            && !i_pause && step_due_c;
    assign sample_c       = !restart_rise_c
                            && (state inside {ST_READY, ST_RUN, ST_PAUSE, ST_STEP});
    assign init_c         = restart_rise_c || (state == ST_CLEAR);

    dir_latch u_dir_latch (
        .clk      (clk),
        .rst      (rst),
        .init     (init_c),
        .sample   (sample_c),
        .commit   (commit_c),
        .up       (i_up),
        .down     (i_down),
        .left     (i_left),
        .right    (i_right),
        .dir      (o_dir),
        .accept_c (accept_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CLEAR;
            frame_cnt    <= '0;
            frame_div    <= DIV_INIT;
            eat_cnt      <= '0;
            restart_q    <= 1'b0;
            clear_issued <= 1'b0;
            o_clear      <= 1'b0;
            o_step       <= 1'b0;
            o_eat        <= 1'b0;
            o_failure    <= 1'b0;
            o_success    <= 1'b0;
        end else begin
            o_clear   <= 1'b0;
            o_step    <= 1'b0;
            o_eat     <= 1'b0;
            restart_q <= i_restart;

            if (restart_rise_c) begin
                // The datapath's outstanding done, if any, completes this clear.
                state        <= ST_CLEAR;
                o_clear      <= 1'b1;
                clear_issued <= 1'b1;
                o_failure    <= 1'b0;
                o_success    <= 1'b0;
                frame_cnt    <= '0;
                frame_div    <= DIV_INIT;
                eat_cnt      <= '0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        frame_cnt <= '0;
                        frame_div <= DIV_INIT;
                        eat_cnt   <= '0;
                        if (!clear_issued) begin
                            o_clear      <= 1'b1;
                            clear_issued <= 1'b1;
                        end else if (i_step_done) begin
                            state <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (accept_c) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (i_frame_start) begin
                            if (i_pause) begin
                                state <= ST_PAUSE;
                            end else if (step_due_c) begin
                                frame_cnt <= '0;
                                o_step    <= 1'b1;
                                state     <= ST_STEP;
                            end else begin
                                frame_cnt <= frame_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (i_frame_start && !i_pause) state <= ST_RUN;
                    end
                    ST_STEP: begin
                        if (i_step_done) begin
                            if (i_eat && !i_collision) begin
                                o_eat <= 1'b1;
                                if (eat_cnt + CNT_ONE == EAT_LIMIT) begin
                                    eat_cnt <= '0;
                                    if (frame_div > DIV_MIN) frame_div <= frame_div - CNT_ONE;
                                end else begin
                                    eat_cnt <= eat_cnt + CNT_ONE;
                                end
                            end
                            if (i_collision) begin
                                state     <= ST_FAIL;
                                o_failure <= 1'b1;
                            end else if (i_board_full) begin
                                state     <= ST_WIN;
                                o_success <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_FAIL, ST_WIN: ;
                    default: state <= ST_CLEAR;
                endcase
            end
        end
    end

    assign o_state = state;
    assign o_tick  = o_step;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: an event-level game model queues expected
// clear/step/eat pulses, and a monitor checks them as the DUT produces them.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int DIV_INIT = 8;
    localparam int DIV_MIN  = 2;
    localparam int SPEED    = 4;

    localparam int S_CLEAR = 0, S_READY = 1, S_RUN = 2, S_PAUSE = 3,
                   S_STEP = 4, S_FAIL = 5, S_WIN = 6;
    localparam int EV_CLEAR = 0, EV_STEP = 1, EV_EAT = 2;

    typedef struct {
        int kind;
        int dir;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_frame_start, i_up, i_down, i_left, i_right, i_pause, i_restart;
    logic       i_step_done, i_eat, i_collision, i_board_full;
    logic       o_clear, o_step, o_failure, o_success, o_eat, o_tick;
    logic [1:0] o_dir;
    logic [2:0] o_state;

    game_sequencer #(
        .FRAME_DIV_INIT (DIV_INIT),
        .FRAME_DIV_MIN  (DIV_MIN),
        .SPEEDUP_EVERY  (SPEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (i_frame_start),
        .i_up          (i_up),
        .i_down        (i_down),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_pause       (i_pause),
        .i_restart     (i_restart),
        .i_step_done   (i_step_done),
        .i_eat         (i_eat),
        .i_collision   (i_collision),
        .i_board_full  (i_board_full),
        .o_clear       (o_clear),
        .o_step        (o_step),
        .o_dir         (o_dir),
        .o_state       (o_state),
        .o_failure     (o_failure),
        .o_success     (o_success),
        .o_eat         (o_eat),
        .o_tick        (o_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  vectors = 0;
    int  miscompares = 0;
    int  steps_seen = 0;
    ev_t exp_q[$];

    // Game model: state, frames since last step, step period, eats toward speed-up, directions.
    int ms, m_cnt, m_period, m_eats, m_dir, m_pend;

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int encode(input logic [3:0] b);
        if (b[3]) return 0;
        if (b[2]) return 1;
        if (b[1]) return 2;
        if (b[0]) return 3;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int dir);
        ev_t e;
        e.kind = kind;
        e.dir  = dir;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int both, input int dir);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || (kind == EV_STEP && (e.dir != dir || both != 3))) begin
            miscompares++;
            $display("FAIL event: got kind %0d dir %0d tick/step %0d cycle %0d, expected kind %0d dir %0d cycle %0d",
                     kind, dir, both, cyc, e.kind, e.dir, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_clear) pop_check(EV_CLEAR, 0, 0);
            if (o_eat)   pop_check(EV_EAT, 0, 0);
            if (o_step || o_tick) begin
                steps_seen++;
                pop_check(EV_STEP, {30'd0, o_tick, o_step}, {30'd0, o_dir});
            end
        end
    end

    task automatic check_status();
        int act;
        int exp;
        act = {25'd0, o_state, o_failure, o_success, o_dir};
        exp = ms * 16 + (ms == S_FAIL ? 8 : 0) + (ms == S_WIN ? 4 : 0) + m_dir;
        check("status {state,fail,win,dir}", act, exp);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        i_frame_start = 0; i_step_done = 0; i_eat = 0; i_collision = 0; i_board_full = 0;
        i_up = 0; i_down = 0; i_left = 0; i_right = 0; i_restart = 0;
    endtask

    task automatic op_idle();
        check_status();
        finish_cycle();
    endtask

    task automatic op_frame();
        check_status();
        i_frame_start = 1;
        case (ms)
            S_RUN: begin
                if (i_pause) ms = S_PAUSE;
                else begin
                    m_cnt++;
                    if (m_cnt == m_period) begin
                        m_cnt = 0;
                        m_dir = m_pend;
                        expect_ev(EV_STEP, m_dir);
                        ms = S_STEP;
                    end
                end
            end
            S_PAUSE: if (!i_pause) ms = S_RUN;
            default: ;
        endcase
        finish_cycle();
    endtask

    task automatic op_press(input logic [3:0] b);
        int req;
        check_status();
        {i_up, i_down, i_left, i_right} = b;
        req = encode(b);
        if ((ms == S_READY || ms == S_RUN || ms == S_PAUSE || ms == S_STEP)
            && req >= 0 && req != opp(m_dir)) begin
            m_pend = req;
            if (ms == S_READY) ms = S_RUN;
        end
        finish_cycle();
    endtask

    task automatic op_done(input logic e, input logic c, input logic f);
        check_status();
        i_step_done = 1; i_eat = e; i_collision = c; i_board_full = f;
        if (ms == S_CLEAR) ms = S_READY;
        else if (ms == S_STEP) begin
            if (e && !c) begin
                expect_ev(EV_EAT, 0);
                m_eats++;
                if (m_eats == SPEED) begin
                    m_eats = 0;
                    if (m_period > DIV_MIN) m_period--;
                end
            end
            ms = c ? S_FAIL : (f ? S_WIN : S_RUN);
        end
        finish_cycle();
    endtask

    task automatic model_init();
        ms = S_CLEAR; m_cnt = 0; m_period = DIV_INIT; m_eats = 0; m_dir = 3; m_pend = 3;
    endtask

    task automatic op_restart();
        check_status();
        i_restart = 1;
        expect_ev(EV_CLEAR, 0);
        model_init();
        finish_cycle();
        op_idle();
    endtask

    // Issue frames until the DUT steps, then return done two cycles later.
    task automatic run_step(input logic e, input logic c, input logic f, output int frames);
        int s0;
        s0 = steps_seen;
        frames = 0;
        while (steps_seen == s0 && frames < 40) begin
            op_frame();
            frames++;
            op_idle();
        end
        check("step arrived", int'(steps_seen != s0), 1);
        op_idle();
        op_done(e, c, f);
    endtask

    initial begin
        int fr;
        int s0;
        int exp_p;
        rst = 1; i_pause = 0;
        i_frame_start = 0; i_step_done = 0; i_eat = 0; i_collision = 0; i_board_full = 0;
        i_up = 0; i_down = 0; i_left = 0; i_right = 0; i_restart = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o_state", int'(o_state), 0);
        check("reset o_dir", int'(o_dir), 3);
        check("reset pulses", int'({o_clear, o_step, o_eat, o_tick}), 0);
        check("reset fail/win", int'({o_failure, o_success}), 0);

        rst = 0;
        model_init();
        expect_ev(EV_CLEAR, 0);
        op_idle();
        op_idle();
        op_done(0, 0, 0);
        op_idle();
        op_press(4'b0001);

        // 16 frames at period 8 give exactly two steps
        s0 = steps_seen;
        repeat (16) begin
            op_frame();
            if (ms == S_STEP) begin op_idle(); op_done(0, 0, 0); end
        end
        check("steps in 16 frames", steps_seen - s0, 2);

        // Reversal rejected, later legal press wins
        op_press(4'b0010);
        op_press(4'b1000);
        run_step(0, 0, 0, fr);
        check("period after turn", fr, 8);
        check("o_dir after up", int'(o_dir), 0);

        // Speed-up every 4 eats down to the floor
        for (int k = 0; k < 28; k++) begin
            run_step(1, 0, 0, fr);
            exp_p = DIV_INIT - k / SPEED;
            if (exp_p < DIV_MIN) exp_p = DIV_MIN;
            check("step period", fr, exp_p);
        end
        run_step(0, 0, 0, fr);
        check("period at floor", fr, DIV_MIN);

        // Collision beats board_full, FAIL ignores frames
        run_step(1, 1, 1, fr);
        op_idle();
        check("o_failure in FAIL", int'(o_failure), 1);
        s0 = steps_seen;
        repeat (20) op_frame();
        check("no steps in FAIL", steps_seen - s0, 0);
        op_restart();
        check("o_failure after restart", int'(o_failure), 0);
        op_done(0, 0, 0);
        op_press(4'b0100);

        // Board full without collision wins
        run_step(0, 0, 1, fr);
        op_idle();
        check("o_success in WIN", int'(o_success), 1);
        op_restart();
        op_done(0, 0, 0);
        op_press(4'b0001);

        // Pause mid-count keeps the frame counter
        repeat (3) op_frame();
        i_pause = 1;
        s0 = steps_seen;
        repeat (30) op_frame();
        check("no steps while paused", steps_seen - s0, 0);
        i_pause = 0;
        op_frame();
        run_step(0, 0, 0, fr);
        check("frames after resume", fr, DIV_INIT - 3);
        i_pause = 1;
        repeat (5) op_frame();
        i_pause = 0;
        op_frame();
        run_step(0, 0, 0, fr);
        check("full period after resume", fr, DIV_INIT);

        // Restart mid-STEP: outstanding done completes the clear
        op_frame();
        while (ms != S_STEP) op_frame();
        op_restart();
        op_done(1, 0, 0);
        op_idle();

        // Randomised play
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1 && ms != S_CLEAR) op_restart();
            else begin
                case (ms)
                    S_CLEAR: if (r < 70) op_done(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                             else op_idle();
                    S_READY: op_press(4'($urandom_range(0, 15)));
                    S_RUN, S_PAUSE: begin
                        if (r < 15) op_press(4'($urandom_range(0, 15)));
                        else if (r < 20) begin i_pause = ~i_pause; op_idle(); end
                        else op_frame();
                    end
                    S_STEP: begin
                        if (r < 40) op_done(1'($urandom_range(0, 1)),
                                            1'($urandom_range(0, 19) == 0),
                                            1'($urandom_range(0, 29) == 0));
                        else if (r < 60) op_frame();
                        else if (r < 75) op_press(4'($urandom_range(0, 15)));
                        else op_idle();
                    end
                    default: begin
                        if (r < 10) op_restart();
                        else if (r < 55) op_frame();
                        else op_press(4'($urandom_range(0, 15)));
                    end
                endcase
            end
        end

        i_pause = 0;
        repeat (4) op_idle();
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
